// File: rtl/qei_speed.sv
// QEI speed sampler: signed position delta per fixed period, valid/ready out.
// Define SPEED_AVG_EN to output the arithmetic mean of the last 4 deltas.
module qei_speed #(
  parameter int nbits  = 16,
  parameter int period = 48000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [nbits-1:0] qei,
  output logic [nbits-1:0] speed,
  output logic             valid,
  input  logic             ready,
  output logic             ovf
);

  localparam int CW = 24;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CW-1:0]    cnt;
  logic             tick;
  logic             load;
  logic             emit;
  logic [nbits-1:0] prev;
  logic [nbits-1:0] delta;
  logic [nbits-1:0] sample;

  assign tick  = en && (cnt == CW'(period - 1));
  // modular subtract: wrap-around lands in the signed range
  assign delta = qei - prev;

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    emit      = 1'b0;
    if (tick) begin
      load = 1'b1;
      unique case (state)
        PRIME: stateNext = RUN;
        RUN:   emit = 1'b1;
      endcase
    end
  end

`ifdef SPEED_AVG_EN
  logic [nbits-1:0]   h0, h1, h2;
  logic [nbits+1:0]   sum;

  assign sum =
    {{2{delta[nbits-1]}}, delta} +
    {{2{h0[nbits-1]}}, h0} +
    {{2{h1[nbits-1]}}, h1} +
    {{2{h2[nbits-1]}}, h2};
  // arithmetic shift by 2, truncated to nbits
  assign sample = sum[nbits+1:2];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
    end else if (emit) begin
      h0 <= delta;
      h1 <= h0;
      h2 <= h1;
    end
  end
`else
  assign sample = delta;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIME;
      cnt   <= '0;
      prev  <= '0;
      speed <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      state <= PRIME;
      cnt   <= '0;
      speed <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= stateNext;
      if (en) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end
      if (load) begin
        prev <= qei;
      end
      if (emit) begin
        speed <= sample;
        valid <= 1'b1;
        if (valid && !ready) begin
          ovf <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/qei_speed.md
QEI_SPEED -- requirements
Module: qei_speed

Interface
REQ-001 Parameter nbits, default 16: width of the QEI position input and of the speed output.
REQ-002 Parameter period, default 48000: clk cycles between samples (1 ms at 48 MHz); legal range 2..2^24-1.
REQ-003 clk  in  1  single clock; all logic is clocked on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  sampling enable; when low, the period counter freezes.
REQ-006 clr  in  1  synchronous clear of measurement state; does not clear parameters.
REQ-007 qei  in  nbits  free-running, wrapping position count from the QEI block.
REQ-008 speed  out  nbits  signed two's-complement counts per period.
REQ-009 valid  out  1  speed holds a new, unconsumed sample.
REQ-010 ready  in  1  consumer (PID) accepts speed on a clk edge where valid=1 and ready=1.
REQ-011 ovf  out  1  sticky flag: an unconsumed sample was overwritten.

Function
REQ-012 Period counter SHALL count 0..period-1 while en=1 and produce a tick on the cycle it equals period-1, then wrap to 0.
REQ-013 The FSM SHALL have two states:
- PRIME: entered on reset or clr; on a tick, latch qei into prev, produce no output, go to RUN.
- RUN: on a tick, compute delta and latch qei into prev.
REQ-014 delta SHALL be (qei - prev) mod 2^nbits, interpreted as signed, so wrap-around is correct for |true delta| < 2^(nbits-1).
REQ-015 Latency: for a tick at cycle T, speed and valid=1 SHALL appear at T+1.
REQ-016 valid SHALL stay high and speed SHALL stay stable until the handshake; valid SHALL drop on the cycle after the handshake unless a new sample lands in that same cycle.
REQ-017 A tick processed while valid=1 and ready=0:
- speed is overwritten with the newer sample;
- valid stays high;
- ovf is set.
REQ-018 A handshake and a new sample landing in the same cycle SHALL consume the old value, leave valid=1 with the new value, and leave ovf unchanged.
REQ-019 ovf SHALL remain set until rst or clr.
REQ-020 en=0 SHALL freeze the counter and suppress ticks. A pending valid/speed SHALL be retained and remain consumable.
REQ-021 clr=1 SHALL:
- zero the counter;
- deassert valid;
- clear ovf;
- zero speed and averaging history;
- enter PRIME.
clr SHALL take priority over en, ticks and handshakes.

Reset
REQ-022 On rst=1 at a clk edge, the block SHALL set:
- speed=0, valid=0, ovf=0;
- counter=0, prev=0, averaging history=0;
- state=PRIME.
REQ-023 rst asserted mid-period or with valid pending SHALL discard all state, with no handshake completing in that cycle.

Configuration
REQ-024 Macro SPEED_AVG_EN defined: speed SHALL be the sum of the last 4 deltas (internal width nbits+2), arithmetic-shifted right by 2 and truncated to nbits. History starts at zero after rst/clr, so the first outputs include zeros.
REQ-025 SPEED_AVG_EN undefined: speed SHALL be the raw delta, and no history registers SHALL be synthesized.

Verification (nbits=16, period=4)
REQ-026 rst held 3 cycles with qei=0x1234 -> speed=0, valid=0, ovf=0; the first tick after release yields no valid (PRIME).
REQ-027 qei=100 at the first tick, 110 at the second, ready=1 -> valid pulses 1 cycle after the second tick with speed=10 (0x000A).
REQ-028 Wrap cases:
- prev=0xFFFE, qei=0x0003 -> speed=0x0005;
- prev=0x0002, qei=0xFFFC -> speed=0xFFFA (-6).
REQ-029 ready=0 across two ticks with deltas 3 then 7 -> speed=7, valid=1, ovf=1; then ready=1 for 1 cycle -> valid=0, ovf still 1; then clr -> ovf=0.
REQ-030 en=0 for 20 cycles with qei changing -> no valid, counter frozen; en=1 resumes counting from the frozen value.
REQ-031 With SPEED_AVG_EN, consecutive deltas 4, 8, 12, 16 -> speed outputs 1, 3, 6, 10; without it -> 4, 8, 12, 16.
